serial_out_decoder: RTL and testbench

SERIAL_OUT_DECODER -- requirements
Module: serial_out_decoder

---
 rtl/serial_out_decoder_if.sv | 26 ++
 rtl/serial_out_decoder.sv | 157 +++++++++++++++
 tb/tb_serial_out_decoder.sv | 285 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_out_decoder_if.sv
// Serial ALU response line and decoded-response bundle for serial_out_decoder.
// The master drives sout and observes the decode; the slave is the decoder.
interface serial_out_decoder_if;
  logic        sout;
  logic        rsp_valid;
  logic        rsp_status;
  logic [31:0] rsp_c;
  logic [3:0]  rsp_flags;
  logic [2:0]  rsp_crc3;
  logic [5:0]  rsp_err_flags;
  logic        rsp_parity;
  logic        rsp_chk_ok;
  logic        frame_err;

  modport master (
    output sout,
    input  rsp_valid, rsp_status, rsp_c, rsp_flags, rsp_crc3,
    input  rsp_err_flags, rsp_parity, rsp_chk_ok, frame_err
  );

  modport slave (
    input  sout,
    output rsp_valid, rsp_status, rsp_c, rsp_flags, rsp_crc3,
    output rsp_err_flags, rsp_parity, rsp_chk_ok, frame_err
  );
endinterface

// File: rtl/serial_out_decoder.sv
// Decodes 11-bit ALU serial packets into OK (4 data + ctl) or ERROR (ctl) responses.
// Define SERIAL_OUT_DECODER_CHK_EN to compute rsp_chk_ok (CRC3 / parity); otherwise it is tied 1.
module serial_out_decoder (
  input logic                 clk,
  input logic                 rst_n,
  serial_out_decoder_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StType, StPayload, StStop} state_e;

  state_e      r_state, w_state_nxt;
  logic        r_type;
  logic [7:0]  r_shift;
  logic [2:0]  r_bit_cnt;
  logic [1:0]  r_data_cnt;
  logic        r_data_full;
  logic [31:0] r_c_acc;

  logic        r_rsp_valid, r_rsp_status, r_rsp_parity, r_frame_err;
  logic [31:0] r_rsp_c;
  logic [3:0]  r_rsp_flags;
  logic [2:0]  r_rsp_crc3;
  logic [5:0]  r_rsp_err_flags;

  logic w_pkt_done, w_is_data, w_is_ok, w_is_err;
  logic w_rsp_ok, w_rsp_err, w_frame_err, w_data_accept, w_clr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= StIdle;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      StIdle:    if (!bus.sout) w_state_nxt = StType;
      StType:    w_state_nxt = StPayload;
      StPayload: if (r_bit_cnt == 3'd7) w_state_nxt = StStop;
      StStop:    w_state_nxt = StIdle;
      default:   w_state_nxt = StIdle;
    endcase
  end

  // Packet-level decode, evaluated on the cycle that samples the stop bit.
  always_comb begin
    w_pkt_done    = (r_state == StStop);
    w_is_data     = w_pkt_done && bus.sout && !r_type;
    w_is_ok       = w_pkt_done && bus.sout && r_type && !r_shift[7];
    w_is_err      = w_pkt_done && bus.sout && r_type && r_shift[7];
    w_rsp_ok      = w_is_ok && r_data_full;
    w_rsp_err     = w_is_err && !r_data_full && (r_data_cnt == 2'd0);
    w_data_accept = w_is_data && !r_data_full;
    w_frame_err   = (w_pkt_done && !bus.sout) || (w_is_data && r_data_full) ||
                    (w_is_ok && !r_data_full) || (w_is_err && !w_rsp_err);
    w_clr_cnt     = w_frame_err || w_rsp_ok || w_rsp_err;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_type      <= 1'b0;
      r_shift     <= '0;
      r_bit_cnt   <= '0;
      r_data_cnt  <= '0;
      r_data_full <= 1'b0;
      r_c_acc     <= '0;
    end else begin
      if (r_state == StType) begin
        r_type    <= bus.sout;
        r_bit_cnt <= '0;
      end
      if (r_state == StPayload) begin
        r_shift   <= {r_shift[6:0], bus.sout};
        r_bit_cnt <= r_bit_cnt + 3'd1;
      end
      if (w_clr_cnt) begin
        r_data_cnt  <= '0;
        r_data_full <= 1'b0;
      end else if (w_data_accept) begin
        r_c_acc    <= {r_c_acc[23:0], r_shift};
        r_data_cnt <= r_data_cnt + 2'd1;
        // Counter wraps to 0 on the 4th byte; the full flag distinguishes 4 from 0.
        if (r_data_cnt == 2'd3) r_data_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid     <= 1'b0;
      r_frame_err     <= 1'b0;
      r_rsp_status    <= 1'b0;
      r_rsp_c         <= '0;
      r_rsp_flags     <= '0;
      r_rsp_crc3      <= '0;
      r_rsp_err_flags <= '0;
      r_rsp_parity    <= 1'b0;
    end else begin
      r_rsp_valid <= w_rsp_ok || w_rsp_err;
      r_frame_err <= w_frame_err;
      if (w_rsp_ok) begin
        r_rsp_status    <= 1'b0;
        r_rsp_c         <= r_c_acc;
        r_rsp_flags     <= r_shift[6:3];
        r_rsp_crc3      <= r_shift[2:0];
        r_rsp_err_flags <= '0;
        r_rsp_parity    <= 1'b0;
      end else if (w_rsp_err) begin
        r_rsp_status    <= 1'b1;
        r_rsp_c         <= '0;
        r_rsp_flags     <= '0;
        r_rsp_crc3      <= '0;
        r_rsp_err_flags <= r_shift[6:1];
        r_rsp_parity    <= r_shift[0];
      end
    end
  end

`ifdef SERIAL_OUT_DECODER_CHK_EN
  logic r_rsp_chk_ok;

  // CRC3, poly x^3+x+1, init 0, MSB first.
  function automatic logic [2:0] crc3_calc(input logic [36:0] msg);
    logic [2:0] crc;
    logic       fb;
    crc = '0;
    for (int i = 36; i >= 0; i--) begin
      fb  = crc[2] ^ msg[i];
      crc = {crc[1], crc[0] ^ fb, fb};
    end
    return crc;
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_chk_ok <= 1'b0;
    end else if (w_rsp_ok) begin
      r_rsp_chk_ok <= (crc3_calc({r_c_acc, 1'b0, r_shift[6:3]}) == r_shift[2:0]);
    end else if (w_rsp_err) begin
      r_rsp_chk_ok <= ~^r_shift;
    end
  end

  assign bus.rsp_chk_ok = r_rsp_chk_ok;
`else
  assign bus.rsp_chk_ok = 1'b1;
`endif

  assign bus.rsp_valid     = r_rsp_valid;
  assign bus.frame_err     = r_frame_err;
  assign bus.rsp_status    = r_rsp_status;
  assign bus.rsp_c         = r_rsp_c;
  assign bus.rsp_flags     = r_rsp_flags;
  assign bus.rsp_crc3      = r_rsp_crc3;
  assign bus.rsp_err_flags = r_rsp_err_flags;
  assign bus.rsp_parity    = r_rsp_parity;

endmodule

// File: tb/tb_serial_out_decoder.sv
// Self-checking bench for serial_out_decoder: directed vector table, reset corner case,
// and randomized frames checked against a packet-level queue model.
module tb_serial_out_decoder;

`ifdef SERIAL_OUT_DECODER_CHK_EN
  localparam bit ChkEn = 1'b1;
`else
  localparam bit ChkEn = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  serial_out_decoder_if bus_if ();

  serial_out_decoder dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit          typ;
    logic [7:0]  pl;
    bit          stp;
    int          gap;
    bit          v;
    bit          f;
    bit          st;
    logic [31:0] c;
    logic [3:0]  fl;
    logic [2:0]  crc;
    logic [5:0]  ef;
    bit          par;
    bit          chk;
  } vec_t;

  // Reference model state: received data bytes and the currently held response.
  logic [7:0]  m_q[$];
  bit          m_st, m_par, m_chk;
  logic [31:0] m_c;
  logic [3:0]  m_fl;
  logic [2:0]  m_crc;
  logic [5:0]  m_ef;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Remainder of msg(x)*x^3 divided by x^3+x+1 via long division.
  function automatic logic [2:0] crc_ref(input logic [36:0] msg);
    logic [39:0] v;
    v = {msg, 3'b000};
    for (int i = 39; i >= 3; i--) if (v[i]) v[i-:4] = v[i-:4] ^ 4'b1011;
    return v[2:0];
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_st = 0; m_c = '0; m_fl = '0; m_crc = '0; m_ef = '0; m_par = 0;
    m_chk = !ChkEn;
  endtask

  task automatic model_pkt(input bit typ, input logic [7:0] pl, input bit stp,
                           output bit ev_v, output bit ev_f);
    ev_v = 0;
    ev_f = 0;
    if (!stp) ev_f = 1;
    else if (!typ) begin
      if (m_q.size() == 4) ev_f = 1;
      else m_q.push_back(pl);
    end else if (!pl[7]) begin
      if (m_q.size() != 4) ev_f = 1;
      else begin
        ev_v = 1;
        m_st = 0; m_c = {m_q[0], m_q[1], m_q[2], m_q[3]};
        m_fl = pl[6:3]; m_crc = pl[2:0]; m_ef = '0; m_par = 0;
        m_chk = ChkEn ? (crc_ref({m_c, 1'b0, pl[6:3]}) == pl[2:0]) : 1'b1;
      end
    end else begin
      if (m_q.size() != 0) ev_f = 1;
      else begin
        ev_v = 1;
        m_st = 1; m_c = '0; m_fl = '0; m_crc = '0; m_ef = pl[6:1]; m_par = pl[0];
        m_chk = ChkEn ? (($countones(pl) % 2) == 0) : 1'b1;
      end
    end
    if (ev_v || ev_f) m_q.delete();
  endtask

  task automatic send_bit(input logic b);
    bus_if.sout = b;
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet();
    check("valid_quiet", {31'd0, bus_if.rsp_valid}, 32'd0);
    check("ferr_quiet", {31'd0, bus_if.frame_err}, 32'd0);
  endtask

  task automatic send_packet(input bit typ, input logic [7:0] pl, input bit stp, input int gap,
                             output bit ev_v, output bit ev_f);
    logic [10:0] pk;
    pk = {1'b0, typ, pl, stp};
    repeat (gap) begin
      send_bit(1'b1);
      check_quiet();
    end
    for (int i = 10; i >= 1; i--) begin
      send_bit(pk[i]);
      check_quiet();
    end
    send_bit(pk[0]);
    model_pkt(typ, pl, stp, ev_v, ev_f);
    check("rsp_valid", {31'd0, bus_if.rsp_valid}, {31'd0, ev_v});
    check("frame_err", {31'd0, bus_if.frame_err}, {31'd0, ev_f});
    check("rsp_status", {31'd0, bus_if.rsp_status}, {31'd0, m_st});
    check("rsp_c", bus_if.rsp_c, m_c);
    check("rsp_flags", {28'd0, bus_if.rsp_flags}, {28'd0, m_fl});
    check("rsp_crc3", {29'd0, bus_if.rsp_crc3}, {29'd0, m_crc});
    check("rsp_err_flags", {26'd0, bus_if.rsp_err_flags}, {26'd0, m_ef});
    check("rsp_parity", {31'd0, bus_if.rsp_parity}, {31'd0, m_par});
    check("rsp_chk_ok", {31'd0, bus_if.rsp_chk_ok}, {31'd0, m_chk});
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_valid"}, {31'd0, bus_if.rsp_valid}, 32'd0);
    check({tag, "_ferr"}, {31'd0, bus_if.frame_err}, 32'd0);
    check({tag, "_status"}, {31'd0, bus_if.rsp_status}, 32'd0);
    check({tag, "_c"}, bus_if.rsp_c, 32'd0);
    check({tag, "_flags"}, {28'd0, bus_if.rsp_flags}, 32'd0);
    check({tag, "_crc3"}, {29'd0, bus_if.rsp_crc3}, 32'd0);
    check({tag, "_err_flags"}, {26'd0, bus_if.rsp_err_flags}, 32'd0);
    check({tag, "_parity"}, {31'd0, bus_if.rsp_parity}, 32'd0);
    check({tag, "_chk_ok"}, {31'd0, bus_if.rsp_chk_ok}, {31'd0, !ChkEn});
  endtask

  function automatic vec_t pk(input bit typ, input logic [7:0] pl, input bit stp, input int gap,
                              input bit f);
    vec_t t;
    t = '{typ: typ, pl: pl, stp: stp, gap: gap, v: 0, f: f, st: 0, c: '0, fl: '0, crc: '0,
          ef: '0, par: 0, chk: 0};
    return t;
  endfunction

  function automatic vec_t rv(input logic [7:0] pl, input int gap, input bit st,
                              input logic [31:0] c, input logic [3:0] fl, input logic [2:0] crc,
                              input logic [5:0] ef, input bit par, input bit chk);
    vec_t t;
    t = '{typ: 1, pl: pl, stp: 1, gap: gap, v: 1, f: 0, st: st, c: c, fl: fl, crc: crc,
          ef: ef, par: par, chk: chk};
    return t;
  endfunction

  initial begin
    vec_t        tbl[$];
    bit          ev_v, ev_f;
    logic [7:0]  b[4];
    logic [3:0]  fl;
    logic [2:0]  crc;
    logic [7:0]  dbe_ctl;
    int          kind, nd, bad;

    dbe_ctl = {1'b0, 4'b1000, crc_ref({32'hDEADBEEF, 1'b0, 4'b1000})};
    // OK frame C=0, flags 0010, crc 110, zero gaps
    repeat (4) tbl.push_back(pk(0, 8'h00, 1, 0, 0));
    tbl.push_back(rv(8'h16, 0, 0, 32'h0, 4'b0010, 3'b110, 6'd0, 0, 1));
    // Same frame with crc 000
    repeat (4) tbl.push_back(pk(0, 8'h00, 1, 0, 0));
    tbl.push_back(rv(8'h10, 0, 0, 32'h0, 4'b0010, 3'b000, 6'd0, 0, !ChkEn));
    // ERROR response
    tbl.push_back(rv(8'hC9, 2, 1, 32'h0, 4'h0, 3'h0, 6'b100100, 1, 1));
    // Bad stop bit in packet 2, then ERROR frame
    tbl.push_back(pk(0, 8'h11, 1, 1, 0));
    tbl.push_back(pk(0, 8'h22, 0, 0, 1));
    tbl.push_back(rv(8'hC9, 0, 1, 32'h0, 4'h0, 3'h0, 6'b100100, 1, 1));
    // Two data packets then OK ctl; counter cleared so ERROR decodes
    tbl.push_back(pk(0, 8'h33, 1, 0, 0));
    tbl.push_back(pk(0, 8'h44, 1, 0, 0));
    tbl.push_back(pk(1, 8'h16, 1, 0, 1));
    tbl.push_back(rv(8'hC9, 0, 1, 32'h0, 4'h0, 3'h0, 6'b100100, 1, 1));
    // Fifth consecutive data packet
    repeat (4) tbl.push_back(pk(0, 8'h5A, 1, 0, 0));
    tbl.push_back(pk(0, 8'hA5, 1, 0, 1));
    // ERROR ctl after one data packet
    tbl.push_back(pk(0, 8'h77, 1, 1, 0));
    tbl.push_back(pk(1, 8'hC9, 1, 0, 1));
    // DEADBEEF frame with 3-cycle gaps
    tbl.push_back(pk(0, 8'hDE, 1, 3, 0));
    tbl.push_back(pk(0, 8'hAD, 1, 3, 0));
    tbl.push_back(pk(0, 8'hBE, 1, 3, 0));
    tbl.push_back(pk(0, 8'hEF, 1, 3, 0));
    tbl.push_back(rv(dbe_ctl, 3, 0, 32'hDEADBEEF, 4'b1000, dbe_ctl[2:0], 6'd0, 0, 1));

    bus_if.sout = 1'b1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;
    repeat (3) begin
      send_bit(1'b1);
      check_quiet();
    end

    for (int i = 0; i < tbl.size(); i++) begin
      vec_t t;
      t = tbl[i];
      send_packet(t.typ, t.pl, t.stp, t.gap, ev_v, ev_f);
      check("tbl_valid", {31'd0, bus_if.rsp_valid}, {31'd0, t.v});
      check("tbl_ferr", {31'd0, bus_if.frame_err}, {31'd0, t.f});
      if (t.v) begin
        check("tbl_status", {31'd0, bus_if.rsp_status}, {31'd0, t.st});
        check("tbl_c", bus_if.rsp_c, t.c);
        check("tbl_flags", {28'd0, bus_if.rsp_flags}, {28'd0, t.fl});
        check("tbl_crc3", {29'd0, bus_if.rsp_crc3}, {29'd0, t.crc});
        check("tbl_err_flags", {26'd0, bus_if.rsp_err_flags}, {26'd0, t.ef});
        check("tbl_parity", {31'd0, bus_if.rsp_parity}, {31'd0, t.par});
        check("tbl_chk_ok", {31'd0, bus_if.rsp_chk_ok}, {31'd0, t.chk});
      end
    end

    // Reset asserted in the middle of packet 3 of a DEADBEEF frame
    send_packet(0, 8'hDE, 1, 3, ev_v, ev_f);
    send_packet(0, 8'hAD, 1, 3, ev_v, ev_f);
    repeat (3) send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    #2 rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    model_reset();
    bus_if.sout = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (5) begin
      send_bit(1'b1);
      check_quiet();
    end
    send_packet(0, 8'hDE, 1, 3, ev_v, ev_f);
    send_packet(0, 8'hAD, 1, 3, ev_v, ev_f);
    send_packet(0, 8'hBE, 1, 3, ev_v, ev_f);
    send_packet(0, 8'hEF, 1, 3, ev_v, ev_f);
    send_packet(1, dbe_ctl, 1, 3, ev_v, ev_f);
    check("post_rst_valid", {31'd0, bus_if.rsp_valid}, 32'd1);
    check("post_rst_c", bus_if.rsp_c, 32'hDEADBEEF);

    // Randomized frames against the queue model
    for (int fr = 0; fr < 40; fr++) begin
      kind = $urandom_range(0, 4);
      for (int k = 0; k < 4; k++) b[k] = 8'($urandom);
      fl  = 4'($urandom);
      crc = crc_ref({b[0], b[1], b[2], b[3], 1'b0, fl});
      if (kind == 1) crc = 3'($urandom);
      bad = (kind == 4) ? $urandom_range(0, 4) : 5;
      if (kind == 2) begin
        send_packet(1, {1'b1, 7'($urandom)}, 1, $urandom_range(0, 3), ev_v, ev_f);
      end else if (kind == 3) begin
        nd = $urandom_range(0, 5);
        for (int k = 0; k < nd; k++)
          send_packet(0, 8'($urandom), 1, $urandom_range(0, 3), ev_v, ev_f);
        send_packet(1, 8'($urandom), 1, $urandom_range(0, 3), ev_v, ev_f);
      end else begin
        for (int k = 0; k < 4; k++)
          send_packet(0, b[k], (k != bad), $urandom_range(0, 3), ev_v, ev_f);
        send_packet(1, {1'b0, fl, crc}, (bad != 4), $urandom_range(0, 3), ev_v, ev_f);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
